mac_matrix_engine: RTL and testbench

Parametrised single-lane matrix-multiply engine, successor to the fixed 32-bit MAC controller. Reads a dimension header and row-major operands from the input and weight SRAMs and computes C = A x B^T (C[i][j] = sum_k A[i][k]*B[j][k]). Writes C row-major to the result SRAM.

---
 rtl/mac_matrix_engine.sv | 209 ++++++++++++++++++++
 tb/tb_mac_matrix_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_matrix_engine.sv
// Single-lane matrix engine: C = A x B^T streamed from input/weight SRAMs into the result SRAM.
// One element per pass: K address pairs, a product stage, an accumulate stage, then one write.
module mac_matrix_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 16,
  parameter int ACC_W  = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              ready,
  output logic              done,
  output logic              error,
  input  logic              cfg_signed,
  input  logic              cfg_relu,
  input  logic              cfg_saturate,
  input  logic              override_dims,
  input  logic [DATA_W-1:0] override_in_dims,
  input  logic [DATA_W-1:0] override_wt_dims,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] wt_base,
  input  logic [ADDR_W-1:0] res_base,
  output logic [DIM_W-1:0]  in_rows,
  output logic [DIM_W-1:0]  in_cols,
  output logic [DIM_W-1:0]  wt_rows,
  output logic [DIM_W-1:0]  wt_cols,
  output logic [ADDR_W-1:0] in_rd_addr,
  output logic [ADDR_W-1:0] wt_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  input  logic [DATA_W-1:0] wt_rd_data,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [DATA_W-1:0] res_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_WAIT, S_CHECK, S_STREAM, S_DRAIN, S_WRITE, S_ERR, S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [DIM_W-1:0]    cnt, i_idx, j_idx, stream_off;
  logic [ADDR_W-1:0]   a_row, b_row, b_row0, res_ptr;
  logic                signed_q, relu_q, saturate_q;
  logic [RD_LAT-1:0]   v_sr, f_sr;
  logic [2*DATA_W-1:0] a_ext, b_ext, prod_full, prod_q;
  logic                prod_v, prod_f;
  logic [ACC_W-1:0]    acc, prod_ext;
  logic                dims_bad, last_j, last_elem, issue, issue_first;

  assign dims_bad    = (in_cols != wt_cols) || (in_rows == '0) || (in_cols == '0) ||
                       (wt_rows == '0) || (wt_cols == '0);
  assign last_j      = (j_idx == wt_rows - DIM_W'(1));
  assign last_elem   = last_j && (i_idx == in_rows - DIM_W'(1));
  assign issue       = (state == S_STREAM);
  assign issue_first = issue && (cnt == in_cols);
  assign stream_off  = in_cols - cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_HDR_WAIT;
      S_HDR_WAIT: if (cnt == DIM_W'(1)) state_nxt = S_CHECK;
      S_CHECK:    state_nxt = dims_bad ? S_ERR : S_STREAM;
      S_STREAM:   if (cnt == DIM_W'(1)) state_nxt = S_DRAIN;
      S_DRAIN:    if (cnt == DIM_W'(1)) state_nxt = S_WRITE;
      S_WRITE:    state_nxt = last_elem ? S_FIN : S_STREAM;
      S_ERR:      state_nxt = S_IDLE;
      S_FIN:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      i_idx      <= '0;
      j_idx      <= '0;
      a_row      <= '0;
      b_row      <= '0;
      b_row0     <= '0;
      res_ptr    <= '0;
      signed_q   <= 1'b0;
      relu_q     <= 1'b0;
      saturate_q <= 1'b0;
      error      <= 1'b0;
      in_rows    <= '0;
      in_cols    <= '0;
      wt_rows    <= '0;
      wt_cols    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          cnt        <= DIM_W'(RD_LAT);
          i_idx      <= '0;
          j_idx      <= '0;
          a_row      <= in_base + ADDR_W'(1);
          b_row      <= wt_base + ADDR_W'(1);
          b_row0     <= wt_base + ADDR_W'(1);
          res_ptr    <= res_base;
          signed_q   <= cfg_signed;
          relu_q     <= cfg_relu;
          saturate_q <= cfg_saturate;
          error      <= 1'b0;
        end
        S_HDR_WAIT: begin
          cnt <= cnt - DIM_W'(1);
          if (cnt == DIM_W'(1)) begin
            {in_rows, in_cols} <= override_dims ? override_in_dims[2*DIM_W-1:0]
                                                : in_rd_data[2*DIM_W-1:0];
            {wt_rows, wt_cols} <= override_dims ? override_wt_dims[2*DIM_W-1:0]
                                                : wt_rd_data[2*DIM_W-1:0];
          end
        end
        S_CHECK: begin
          cnt <= in_cols;
          if (dims_bad) error <= 1'b1;
        end
        S_STREAM: cnt <= (cnt == DIM_W'(1)) ? DIM_W'(RD_LAT + 2) : cnt - DIM_W'(1);
        S_DRAIN:  cnt <= cnt - DIM_W'(1);
        S_WRITE: begin
          cnt     <= in_cols;
          res_ptr <= res_ptr + ADDR_W'(1);
          if (last_j) begin
            j_idx <= '0;
            b_row <= b_row0;
            i_idx <= i_idx + DIM_W'(1);
            a_row <= a_row + ADDR_W'(in_cols);
          end else begin
            j_idx <= j_idx + DIM_W'(1);
            b_row <= b_row + ADDR_W'(in_cols);
          end
        end
        default: ;
      endcase
    end
  end

  // Products are formed at full width; extension follows the operand signedness.
  assign a_ext     = signed_q ? (2*DATA_W)'(signed'(in_rd_data)) : (2*DATA_W)'(in_rd_data);
  assign b_ext     = signed_q ? (2*DATA_W)'(signed'(wt_rd_data)) : (2*DATA_W)'(wt_rd_data);
  assign prod_full = a_ext * b_ext;
  assign prod_ext  = signed_q ? ACC_W'(signed'(prod_q)) : ACC_W'(prod_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_sr   <= '0;
      f_sr   <= '0;
      prod_q <= '0;
      prod_v <= 1'b0;
      prod_f <= 1'b0;
      acc    <= '0;
    end else begin
      v_sr   <= RD_LAT'({v_sr, issue});
      f_sr   <= RD_LAT'({f_sr, issue_first});
      prod_v <= v_sr[RD_LAT-1];
      prod_f <= f_sr[RD_LAT-1];
      if (v_sr[RD_LAT-1]) prod_q <= prod_full;
      if (prod_v) acc <= (prod_f ? '0 : acc) + prod_ext;
    end
  end

  always_comb begin
    res_wr_data = acc[DATA_W-1:0];
    if (relu_q && signed_q && acc[ACC_W-1]) begin
      res_wr_data = '0;
    end else if (saturate_q) begin
      if (signed_q) begin
        if (acc[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){acc[ACC_W-1]}})
          res_wr_data = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else if (acc[ACC_W-1:DATA_W] != '0) begin
        res_wr_data = '1;
      end
    end
  end

  // Header address goes out combinationally in the start cycle so the latch lands at the end of HDR_WAIT.
  always_comb begin
    in_rd_addr = '0;
    wt_rd_addr = '0;
    case (state)
      S_IDLE: if (start) begin
        in_rd_addr = in_base;
        wt_rd_addr = wt_base;
      end
      S_HDR_WAIT: begin
        in_rd_addr = a_row - ADDR_W'(1);
        wt_rd_addr = b_row0 - ADDR_W'(1);
      end
      S_STREAM: begin
        in_rd_addr = a_row + ADDR_W'(stream_off);
        wt_rd_addr = b_row + ADDR_W'(stream_off);
      end
      default: ;
    endcase
  end

  assign ready       = (state == S_IDLE);
  assign done        = (state == S_FIN) || (state == S_ERR);
  assign res_wr_en   = (state == S_WRITE);
  assign res_wr_addr = res_ptr;

endmodule

// File: tb/tb_mac_matrix_engine.sv
// Directed bench for mac_matrix_engine: one instance at RD_LAT=1, one at RD_LAT=3, behind latency-matched SRAM models.
module tb_mac_matrix_engine;

  logic clk = 1'b0, reset_n = 1'b0, start1 = 1'b0, start3 = 1'b0, abort = 1'b0;
  logic cfg_signed = 1'b0, cfg_relu = 1'b0, cfg_saturate = 1'b0, override_dims = 1'b0;
  logic [31:0] ovr_in = '0, ovr_wt = '0;
  logic [11:0] in_base = 12'h000, wt_base = 12'h100, res_base = 12'h010;

  logic        ready1, done1, error1, wr_en1, ready3, done3, error3, wr_en3;
  logic [15:0] in_rows1, in_cols1, wt_rows1, wt_cols1, in_rows3, in_cols3, wt_rows3, wt_cols3;
  logic [11:0] in_addr1, wt_addr1, wr_addr1, in_addr3, wt_addr3, wr_addr3;
  logic [31:0] in_data1, wt_data1, wr_data1, in_data3, wt_data3, wr_data3;

  logic [31:0] in_mem [0:4095];
  logic [31:0] wt_mem [0:4095];
  logic [31:0] p3_in [3];
  logic [31:0] p3_wt [3];

  int cyc = 0, dn1 = 0, dc1 = 0, dn3 = 0, dc3 = 0;
  logic [11:0] wa1[$], wa3[$];
  logic [31:0] wd1[$], wd3[$];
  int wc1[$], wc3[$];
  int n_chk = 0, n_err = 0;

  mac_matrix_engine #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort),
    .ready(ready1), .done(done1), .error(error1),
    .cfg_signed(cfg_signed), .cfg_relu(cfg_relu), .cfg_saturate(cfg_saturate),
    .override_dims(override_dims), .override_in_dims(ovr_in), .override_wt_dims(ovr_wt),
    .in_base(in_base), .wt_base(wt_base), .res_base(res_base),
    .in_rows(in_rows1), .in_cols(in_cols1), .wt_rows(wt_rows1), .wt_cols(wt_cols1),
    .in_rd_addr(in_addr1), .wt_rd_addr(wt_addr1), .in_rd_data(in_data1), .wt_rd_data(wt_data1),
    .res_wr_en(wr_en1), .res_wr_addr(wr_addr1), .res_wr_data(wr_data1));

  mac_matrix_engine #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .abort(abort),
    .ready(ready3), .done(done3), .error(error3),
    .cfg_signed(cfg_signed), .cfg_relu(cfg_relu), .cfg_saturate(cfg_saturate),
    .override_dims(override_dims), .override_in_dims(ovr_in), .override_wt_dims(ovr_wt),
    .in_base(in_base), .wt_base(wt_base), .res_base(res_base),
    .in_rows(in_rows3), .in_cols(in_cols3), .wt_rows(wt_rows3), .wt_cols(wt_cols3),
    .in_rd_addr(in_addr3), .wt_rd_addr(wt_addr3), .in_rd_data(in_data3), .wt_rd_data(wt_data3),
    .res_wr_en(wr_en3), .res_wr_addr(wr_addr3), .res_wr_data(wr_data3));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    in_data1 <= in_mem[in_addr1];
    wt_data1 <= wt_mem[wt_addr1];
    p3_in[0] <= in_mem[in_addr3];
    p3_wt[0] <= wt_mem[wt_addr3];
    p3_in[1] <= p3_in[0];
    p3_wt[1] <= p3_wt[0];
    p3_in[2] <= p3_in[1];
    p3_wt[2] <= p3_wt[1];
  end
  assign in_data3 = p3_in[2];
  assign wt_data3 = p3_wt[2];

  // Monitor: cyc read here is the index of the cycle that this edge closes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en1) begin wa1.push_back(wr_addr1); wd1.push_back(wr_data1); wc1.push_back(cyc); end
    if (wr_en3) begin wa3.push_back(wr_addr3); wd3.push_back(wr_data3); wc3.push_back(cyc); end
    if (done1) begin dn1 <= dn1 + 1; dc1 <= cyc; end
    if (done3) begin dn3 <= dn3 + 1; dc3 <= cyc; end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input int d, output int s);
    int n0;
    n0 = (d == 1) ? dn1 : dn3;
    if (d == 1) start1 = 1'b1; else start3 = 1'b1;
    s = cyc;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    for (int t = 0; t < 300 && (((d == 1) ? dn1 : dn3) == n0); t++) @(negedge clk);
    chk("done_seen", ((d == 1) ? dn1 : dn3) - n0, 1);
  endtask

  task automatic chk_wr(input string tag, input int d, input int wb, input int s, input int n,
                        input int first, input int per, input logic [31:0] ed [4]);
    int sz;
    sz = (d == 1) ? wa1.size() : wa3.size();
    chk({tag, "_nwr"}, sz - wb, n);
    for (int e = 0; e < n && wb + e < sz; e++) begin
      if (d == 1) begin
        chk({tag, "_addr"}, wa1[wb+e], res_base + e);
        chk({tag, "_data"}, wd1[wb+e], ed[e]);
        chk({tag, "_cyc"}, wc1[wb+e] - s, first + e * per);
      end else begin
        chk({tag, "_addr"}, wa3[wb+e], res_base + e);
        chk({tag, "_data"}, wd3[wb+e], ed[e]);
        chk({tag, "_cyc"}, wc3[wb+e] - s, first + e * per);
      end
    end
  endtask

  task automatic load_2x2;
    in_mem[0] = {16'd2, 16'd2};
    in_mem[1] = 1; in_mem[2] = 2; in_mem[3] = 3; in_mem[4] = 4;
    wt_mem[12'h100] = {16'd2, 16'd2};
    wt_mem[12'h101] = 5; wt_mem[12'h102] = 6; wt_mem[12'h103] = 7; wt_mem[12'h104] = 8;
  endtask

  initial begin
    int s, wb, n0;
    logic [31:0] ex [4];
    for (int a = 0; a < 4096; a++) begin in_mem[a] = '0; wt_mem[a] = '0; end

    repeat (3) @(negedge clk);
    chk("rst_ready", ready1, 1);
    chk("rst_done", done1, 0);
    chk("rst_error", error1, 0);
    chk("rst_wr_en", wr_en1, 0);
    chk("rst_wr_data", wr_data1, 0);
    chk("rst_in_rows", in_rows1, 0);
    chk("rst_in_addr", in_addr1, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 2x2x2 unsigned
    load_2x2();
    wb = wa1.size();
    run_job(1, s);
    ex = '{32'd17, 32'd23, 32'd39, 32'd53};
    chk_wr("mm2x2", 1, wb, s, 4, 8, 6, ex);
    chk("mm2x2_done_lat", dc1 - s, 27);
    chk("mm2x2_dims", {in_rows1, in_cols1, wt_rows1, wt_cols1}, 64'h0002_0002_0002_0002);
    chk("mm2x2_error", error1, 0);

    // signed with ReLU, then without
    in_mem[0] = {16'd1, 16'd2}; in_mem[1] = 32'hFFFF_FFFF; in_mem[2] = 32'hFFFF_FFFE;
    wt_mem[12'h100] = {16'd2, 16'd2};
    wt_mem[12'h101] = 3; wt_mem[12'h102] = 4; wt_mem[12'h103] = 1; wt_mem[12'h104] = 1;
    cfg_signed = 1'b1; cfg_relu = 1'b1;
    wb = wa1.size();
    run_job(1, s);
    ex = '{32'd0, 32'd0, 32'd0, 32'd0};
    chk_wr("relu", 1, wb, s, 2, 8, 6, ex);
    chk("relu_done_lat", dc1 - s, 15);
    cfg_relu = 1'b0;
    wb = wa1.size();
    run_job(1, s);
    ex = '{32'hFFFF_FFF5, 32'hFFFF_FFFD, 32'd0, 32'd0};
    chk_wr("signed_raw", 1, wb, s, 2, 8, 6, ex);

    // saturation at 1x1x1
    in_mem[0] = {16'd1, 16'd1}; in_mem[1] = 32'h7FFF_FFFF;
    wt_mem[12'h100] = {16'd1, 16'd1}; wt_mem[12'h101] = 2;
    cfg_saturate = 1'b1;
    wb = wa1.size();
    run_job(1, s);
    ex = '{32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0};
    chk_wr("sat_pos", 1, wb, s, 1, 7, 5, ex);
    chk("sat_done_lat", dc1 - s, 8);
    cfg_saturate = 1'b0;
    wb = wa1.size();
    run_job(1, s);
    ex = '{32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0};
    chk_wr("nosat", 1, wb, s, 1, 7, 5, ex);
    cfg_saturate = 1'b1; in_mem[1] = 32'h8000_0000;
    wb = wa1.size();
    run_job(1, s);
    ex = '{32'h8000_0000, 32'd0, 32'd0, 32'd0};
    chk_wr("sat_neg", 1, wb, s, 1, 7, 5, ex);
    cfg_signed = 1'b0; in_mem[1] = 32'hFFFF_FFFF;
    wb = wa1.size();
    run_job(1, s);
    ex = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    chk_wr("sat_uns", 1, wb, s, 1, 7, 5, ex);
    cfg_saturate = 1'b0;

    // dimension mismatch and zero dimension
    in_mem[0] = {16'd2, 16'd3}; wt_mem[12'h100] = {16'd2, 16'd2};
    wb = wa1.size();
    run_job(1, s);
    chk("err_nwr", wa1.size() - wb, 0);
    chk("err_done_lat", dc1 - s, 3);
    chk("err_flag", error1, 1);
    chk("err_ready", ready1, 1);
    chk("err_in_cols", in_cols1, 3);
    in_mem[0] = {16'd0, 16'd2};
    wb = wa1.size();
    run_job(1, s);
    chk("zero_nwr", wa1.size() - wb, 0);
    chk("zero_flag", error1, 1);
    load_2x2();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("err_cleared_at_start", error1, 0);
    for (int t = 0; t < 100 && !ready1; t++) @(negedge clk);
    chk("err_clear_job_idle", ready1, 1);

    // abort during element 1 STREAM
    repeat (2) @(negedge clk);
    wb = wa1.size(); n0 = dn1;
    start1 = 1'b1; s = cyc;
    @(negedge clk);
    start1 = 1'b0;
    for (int t = 0; t < 50 && cyc < s + 9; t++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", ready1, 1);
    repeat (30) @(negedge clk);
    chk("abort_nwr", wa1.size() - wb, 1);
    if (wa1.size() > wb) chk("abort_wr0_data", wd1[wb], 17);
    chk("abort_no_done", dn1 - n0, 0);
    chk("abort_error", error1, 0);

    // reset during the first WRITE cycle
    wb = wa1.size(); n0 = dn1;
    start1 = 1'b1; s = cyc;
    @(negedge clk);
    start1 = 1'b0;
    for (int t = 0; t < 50 && cyc < s + 8; t++) @(negedge clk);
    chk("pre_rst_wr_en", wr_en1, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", wr_en1, 0);
    chk("rst_mid_ready", ready1, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_mid_nwr", wa1.size() - wb, 0);
    chk("rst_mid_no_done", dn1 - n0, 0);

    // RD_LAT=3 with override dims and junk headers
    load_2x2();
    in_mem[0] = 32'hDEAD_BEEF; wt_mem[12'h100] = 32'h1234_5678;
    override_dims = 1'b1; ovr_in = {16'd2, 16'd2}; ovr_wt = {16'd2, 16'd2};
    wb = wa3.size();
    run_job(3, s);
    ex = '{32'd17, 32'd23, 32'd39, 32'd53};
    chk_wr("lat3", 3, wb, s, 4, 12, 8, ex);
    chk("lat3_done_lat", dc3 - s, 37);
    chk("lat3_dims", {in_rows3, in_cols3, wt_rows3, wt_cols3}, 64'h0002_0002_0002_0002);
    chk("lat3_state", {ready3, error3}, 2'b10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
